// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider. Each channel owns a double-buffered divide
// value that takes effect at the end of a full sclk period, on sync, or at once while disabled.
module clk_divider_multi #(
    parameter int               CHANNELS  = 4,
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_DIV = WIDTH'(32'd799999),
    parameter int               CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_div,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    output logic [CHANNELS-1:0] sclk,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pend
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] r_count;
        logic [WIDTH-1:0] r_active;
        logic [WIDTH-1:0] r_shadow;
        logic             r_sclk;
        logic             r_tick;
        logic             r_pend;
        logic             w_wr_hit;
        logic             w_wrap;
        logic             w_xfer;

        // Only in-range channel numbers can match, so writes to wr_ch >= CHANNELS fall through.
        assign w_wr_hit = wr_en && (wr_ch == CH_W'(g));
        assign w_wrap   = (r_count >= r_active);
        // Shadow moves to active on the falling toggle, on sync, or straight away when stopped.
        assign w_xfer   = r_pend && (sync || !en[g] || (w_wrap && r_sclk));

        // NOTE: the per-channel divide registers are plain flops, so they are reset like everything else.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_count  <= '0;
                r_active <= RESET_DIV;
                r_shadow <= RESET_DIV;
                r_sclk   <= 1'b0;
                r_tick   <= 1'b0;
                r_pend   <= 1'b0;
            end else begin
                if (w_xfer) begin
                    r_active <= r_shadow;
                end
                if (w_wr_hit) begin
                    r_shadow <= wr_div;
                end
                // A write landing on the transfer cycle keeps pend set for the new value.
                if (w_wr_hit) begin
                    r_pend <= 1'b1;
                end else if (w_xfer) begin
                    r_pend <= 1'b0;
                end

                r_tick <= 1'b0;
                if (sync) begin
                    r_count <= '0;
                    r_sclk  <= 1'b0;
                end else if (en[g]) begin
                    if (w_wrap) begin
                        r_count <= '0;
                        r_sclk  <= ~r_sclk;
                        // NOTE: non-blocking, so r_sclk here is the pre-toggle value; 0 means a rising edge.
                        r_tick  <= ~r_sclk;
                    end else begin
                        r_count <= r_count + WIDTH'(1);
                    end
                end
            end
        end

        assign sclk[g] = r_sclk;
        assign tick[g] = r_tick;
        assign pend[g] = r_pend;
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi: a vector table for start-up and out-of-range writes,
// followed by hand-timed sequences for pending transfers, enable gaps, sync, max divide and async reset.
module tb_clk_divider_multi;

    localparam int CHANNELS = 3;
    localparam int WIDTH    = 8;
    localparam int CH_W     = 2;

    logic                clk    = 1'b0;
    logic                rst_n  = 1'b0;
    logic                wr_en  = 1'b0;
    logic [CH_W-1:0]     wr_ch  = '0;
    logic [WIDTH-1:0]    wr_div = '0;
    logic [CHANNELS-1:0] en     = '0;
    logic                sync   = 1'b0;
    logic [CHANNELS-1:0] sclk;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] pend;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic             wr_en;
        logic [CH_W-1:0]  wr_ch;
        logic [WIDTH-1:0] wr_div;
        logic [2:0]       en;
        logic             sync;
        logic [2:0]       exp_sclk;
        logic [2:0]       exp_tick;
        logic [2:0]       exp_pend;
    } vec_t;

    vec_t vecs [16];

    clk_divider_multi #(
        .CHANNELS (CHANNELS),
        .WIDTH    (WIDTH),
        .RESET_DIV(8'd3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en),
        .wr_ch (wr_ch),
        .wr_div(wr_div),
        .en    (en),
        .sync  (sync),
        .sclk  (sclk),
        .tick  (tick),
        .pend  (pend)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Steps until sclk[ch] reads val; n returns the edges taken, limit+1 on timeout.
    task automatic wait_for(input int ch, input logic val, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (sclk[ch] !== val && n <= limit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        logic       hi;
        logic [2:0] es;
        logic [2:0] et;

        // Start-up with RESET_DIV=3: rise after 4 clks, period 8; wr_ch=3 writes must be ignored.
        vecs[0]  = '{1'b0, 2'd0, 8'd0, 3'b111, 1'b0, 3'b000, 3'b000, 3'b000};
        vecs[1]  = '{1'b1, 2'd3, 8'd0, 3'b111, 1'b0, 3'b000, 3'b000, 3'b000};
        vecs[2]  = '{1'b0, 2'd0, 8'd0, 3'b111, 1'b0, 3'b000, 3'b000, 3'b000};
        vecs[3]  = '{1'b0, 2'd0, 8'd0, 3'b111, 1'b0, 3'b111, 3'b111, 3'b000};
        vecs[4]  = '{1'b0, 2'd0, 8'd0, 3'b111, 1'b0, 3'b111, 3'b000, 3'b000};
        vecs[5]  = '{1'b0, 2'd0, 8'd0, 3'b111, 1'b0, 3'b111, 3'b000, 3'b000};
        vecs[6]  = '{1'b0, 2'd0, 8'd0, 3'b111, 1'b0, 3'b111, 3'b000, 3'b000};
        vecs[7]  = '{1'b0, 2'd0, 8'd0, 3'b111, 1'b0, 3'b000, 3'b000, 3'b000};
        vecs[8]  = '{1'b1, 2'd3, 8'd7, 3'b111, 1'b0, 3'b000, 3'b000, 3'b000};
        vecs[9]  = '{1'b0, 2'd0, 8'd0, 3'b111, 1'b0, 3'b000, 3'b000, 3'b000};
        vecs[10] = '{1'b0, 2'd0, 8'd0, 3'b111, 1'b0, 3'b000, 3'b000, 3'b000};
        vecs[11] = '{1'b0, 2'd0, 8'd0, 3'b111, 1'b0, 3'b111, 3'b111, 3'b000};
        vecs[12] = '{1'b0, 2'd0, 8'd0, 3'b111, 1'b0, 3'b111, 3'b000, 3'b000};
        vecs[13] = '{1'b0, 2'd0, 8'd0, 3'b111, 1'b0, 3'b111, 3'b000, 3'b000};
        vecs[14] = '{1'b0, 2'd0, 8'd0, 3'b111, 1'b0, 3'b111, 3'b000, 3'b000};
        vecs[15] = '{1'b0, 2'd0, 8'd0, 3'b111, 1'b0, 3'b000, 3'b000, 3'b000};

        // Outputs stay at reset values while rst_n is low, even with clocks and enables.
        en = 3'b111;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("reset_hold[%0d]", i), 32'({sclk, tick, pend}), 32'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            wr_en  = vecs[i].wr_en;
            wr_ch  = vecs[i].wr_ch;
            wr_div = vecs[i].wr_div;
            en     = vecs[i].en;
            sync   = vecs[i].sync;
            step();
            check($sformatf("table[%0d]", i), 32'({sclk, tick, pend}),
                  32'({vecs[i].exp_sclk, vecs[i].exp_tick, vecs[i].exp_pend}));
        end
        wr_en = 1'b0;

        // Edge 20: all channels rise again.
        for (int i = 0; i < 3; i++) step();
        step();
        check("rise_edge20", 32'({sclk, tick}), 32'({3'b111, 3'b111}));

        // Write div=0 to ch1 while sclk[1]=1; it waits for the falling toggle at edge 24.
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd0;
        step();
        wr_en = 1'b0;
        check("pend_set_ch1", 32'({sclk, pend}), 32'({3'b111, 3'b010}));
        step();
        step();
        check("pend_held_ch1", 32'({sclk, pend}), 32'({3'b111, 3'b010}));
        step();
        check("pend_clear_on_fall", 32'({sclk, pend}), 32'({3'b000, 3'b000}));

        // Edges 25..32: ch1 toggles every clk, ch0/ch2 keep their 8-clk period.
        for (int k = 25; k <= 32; k++) begin
            step();
            hi = (k >= 28 && k <= 31);
            es = {hi, k[0], hi};
            et = {k == 28, k[0], k == 28};
            check($sformatf("div0_ch1_edge%0d", k), 32'({sclk, tick}), 32'({es, et}));
        end

        // ch2 paused for 10 clks with count at 2; ch0 keeps running.
        step();
        step();
        en = 3'b011;
        for (int k = 35; k <= 44; k++) begin
            step();
            hi = (k >= 36 && k <= 39) || (k == 44);
            check($sformatf("ch2_paused_edge%0d", k), 32'({sclk[2], tick[2], sclk[0]}),
                  32'({1'b0, 1'b0, hi}));
        end
        en = 3'b111;
        wait_for(2, 1'b1, 20, n);
        check("ch2_resume_rise_clks", n, 2);
        check("ch2_resume_tick", 32'(tick[2]), 32'd1);
        wait_for(2, 1'b0, 20, n);
        check("ch2_resume_fall_clks", n, 4);

        // Disabled channel transfers next clk; a write on the transfer cycle keeps pend set.
        en = 3'b011;
        wr_en = 1'b1; wr_ch = 2'd2; wr_div = 8'd1;
        step();
        check("ch2_off_pend_set", 32'(pend[2]), 32'd1);
        wr_div = 8'd2;
        step();
        check("ch2_coincide_pend", 32'(pend[2]), 32'd1);
        wr_en = 1'b0;
        step();
        check("ch2_off_xfer_clear", 32'(pend[2]), 32'd0);

        // ch0 pending div=2 at sync; a same-cycle write to ch1 lands with pend=1.
        en = 3'b111;
        wr_en = 1'b1; wr_ch = 2'd0; wr_div = 8'd2;
        step();
        check("ch0_pend_before_sync", 32'(pend[0]), 32'd1);
        wr_ch = 2'd1; wr_div = 8'd0; sync = 1'b1;
        step();
        wr_en = 1'b0; sync = 1'b0;
        check("sync_state", 32'({sclk, tick, pend}), 32'({3'b000, 3'b000, 3'b010}));
        for (int k = 1; k <= 8; k++) begin
            step();
            hi = (k >= 3 && k <= 5);
            es = {hi, k[0], hi};
            et = {k == 3, k[0], k == 3};
            check($sformatf("post_sync_clk%0d", k), 32'({sclk, tick}), 32'({es, et}));
        end

        // Maximum divide value: half period of 256 clks, no wrap.
        wr_en = 1'b1; wr_ch = 2'd2; wr_div = 8'd255;
        step();
        wr_en = 1'b0; sync = 1'b1;
        step();
        sync = 1'b0;
        check("max_div_pend_clear", 32'(pend[2]), 32'd0);
        wait_for(2, 1'b1, 300, n);
        check("max_div_rise_clks", n, 256);
        check("max_div_tick", 32'(tick[2]), 32'd1);
        wait_for(2, 1'b0, 300, n);
        check("max_div_fall_clks", n, 256);

        // Asynchronous reset between edges while sclk[0]=1 and pend[1]=1.
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd0;
        wait_for(0, 1'b1, 20, n);
        check("pre_reset_state", 32'({sclk[0], pend[1]}), 32'({1'b1, 1'b1}));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", 32'({sclk, tick, pend}), 32'd0);
        wr_en = 1'b0;
        step();
        step();
        check("async_reset_held", 32'({sclk, tick, pend}), 32'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            es = (k == 4) ? 3'b111 : 3'b000;
            check($sformatf("after_reset_clk%0d", k), 32'({sclk, tick}), 32'({es, es}));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
